// File: rtl/screen_pkg.sv
// Shared definitions for the VGA scene path.
//   scene_t  : scene encoding driven on screen_sequencer.scene
//   rgb12_t  : 12-bit {r,g,b} pixel as produced by every drawer
//   BDR..TKN : tile codes shared between the drawers and the sequencer
//   max_int  : elaboration-time helper for sizing counters
package screen_pkg;

    typedef enum logic [2:0] {
        TITLE     = 3'd0,
        PLAYING   = 3'd1,
        DYING     = 3'd2,
        GAME_OVER = 3'd3,
        WIN       = 3'd4
    } scene_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    localparam logic [2:0] BDR = 3'd0;
    localparam logic [2:0] SKY = 3'd1;
    localparam logic [2:0] BLK = 3'd2;
    localparam logic [2:0] GND = 3'd3;
    localparam logic [2:0] TKN = 3'd4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/screen_sequencer_button_edge_sync.sv
// Two-flop synchroniser for a raw asynchronous button followed by a
// registered rising-edge detector.
//   clk    : destination clock
//   rst    : asynchronous active-high reset
//   button : raw button level, active-high
//   pulse  : one-cycle pulse, three clocks after the button rises
module button_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic pulse
);

    logic meta;
    logic stable;
    logic stable_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta     <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            pulse    <= 1'b0;
        end else begin
            meta     <= button;
            stable   <= meta;
            stable_d <= stable;
            pulse    <= stable & ~stable_d;
        end
    end

endmodule

// File: rtl/screen_sequencer.sv
// Scene controller for the VGA path: picks which drawer owns the pixel
// output, tracks lives and issues gameplay restart pulses. Scene changes
// happen only on frame_tick, so every frame is drawn by a single scene.
//   vga_clock, reset          : pixel clock, async active-high reset
//   row, column               : scan position from the timing generator
//   display_enable            : high in the visible area
//   jump_button               : raw button, active-high
//   mario_dead, level_done    : level flags from gameplay logic
//   title/play/over/win_rgb   : drawer pixels {r,g,b}
//   vga_red/green/blue        : registered muxed pixel
//   scene, lives              : current scene and remaining lives
//   play_restart              : one-cycle gameplay world reset
//   frame_tick                : one-cycle pulse at start of vertical blanking
module screen_sequencer
    import screen_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int START_LIVES   = 3,
    parameter int DEATH_FRAMES  = 120,
    parameter int OVER_FRAMES   = 300
) (
    input  logic        vga_clock,
    input  logic        reset,
    input  logic [31:0] row,
    input  logic [31:0] column,
    input  logic        display_enable,
    input  logic        jump_button,
    input  logic        mario_dead,
    input  logic        level_done,
    input  logic [11:0] title_rgb,
    input  logic [11:0] play_rgb,
    input  logic [11:0] over_rgb,
    input  logic [11:0] win_rgb,
    output logic [3:0]  vga_red,
    output logic [3:0]  vga_green,
    output logic [3:0]  vga_blue,
    output scene_t      scene,
    output logic [2:0]  lives,
    output logic        play_restart,
    output logic        frame_tick
);

    localparam int TW = $clog2(max_int(DEATH_FRAMES, OVER_FRAMES) + 1);
    localparam logic [TW-1:0] DEATH_LAST  = TW'(DEATH_FRAMES - 1);
    localparam logic [TW-1:0] OVER_LAST   = TW'(OVER_FRAMES);
    localparam logic [2:0]    LIVES_START = 3'(START_LIVES);

    if (SCREEN_WIDTH < 1 || SCREEN_HEIGHT < 1 || START_LIVES < 1 || START_LIVES > 7
        || DEATH_FRAMES < 1 || OVER_FRAMES < 1) begin : g_bad_params
        $error("screen_sequencer: parameter out of range");
    end

    logic          btn_pulse;
    logic          btn_pending;
    logic          at_blank_start;
    logic          at_blank_start_d;
    logic [TW-1:0] timer;
    logic          de_d;
    rgb12_t        pixel;

    button_edge_sync u_jump (
        .clk    (vga_clock),
        .rst    (reset),
        .button (jump_button),
        .pulse  (btn_pulse)
    );

    always_comb begin
        at_blank_start = (row == 32'(SCREEN_HEIGHT)) && (column == '0);
    end

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            at_blank_start_d <= 1'b0;
            frame_tick       <= 1'b0;
            scene            <= TITLE;
            lives            <= LIVES_START;
            timer            <= '0;
            btn_pending      <= 1'b0;
            play_restart     <= 1'b0;
        end else begin
            at_blank_start_d <= at_blank_start;
            // Edge of the position compare: a generator that dwells on the
            // blanking start still yields a single tick.
            frame_tick       <= at_blank_start && !at_blank_start_d;
            play_restart     <= 1'b0;

            if (frame_tick) begin
                // Each tick consumes any pending press; a press arriving on
                // the tick itself is carried to the next frame unless the
                // scene changes below.
                btn_pending <= btn_pulse;
                unique case (scene)
                    TITLE: begin
                        if (btn_pending) begin
                            scene        <= PLAYING;
                            lives        <= LIVES_START;
                            play_restart <= 1'b1;
                            btn_pending  <= 1'b0;
                        end
                    end
                    PLAYING: begin
                        if (mario_dead) begin
                            scene       <= DYING;
                            timer       <= '0;
                            btn_pending <= 1'b0;
                        end else if (level_done) begin
                            scene       <= WIN;
                            timer       <= '0;
                            btn_pending <= 1'b0;
                        end
                    end
                    DYING: begin
                        if (timer == DEATH_LAST) begin
                            timer       <= '0;
                            btn_pending <= 1'b0;
                            if (lives <= 3'd1) begin
                                lives <= '0;
                                scene <= GAME_OVER;
                            end else begin
                                lives        <= lives - 3'd1;
                                scene        <= PLAYING;
                                play_restart <= 1'b1;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    GAME_OVER, WIN: begin
                        if (timer == OVER_LAST) begin
                            if (btn_pending) begin
                                scene       <= TITLE;
                                btn_pending <= 1'b0;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    default: begin
                        scene       <= TITLE;
                        btn_pending <= 1'b0;
                    end
                endcase
            end else if (btn_pulse) begin
                btn_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        unique case (scene)
            TITLE:          pixel = title_rgb;
            PLAYING, DYING: pixel = play_rgb;
            GAME_OVER:      pixel = over_rgb;
            WIN:            pixel = win_rgb;
            default:        pixel = '0;
        endcase
    end

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            de_d      <= 1'b0;
            vga_red   <= '0;
            vga_green <= '0;
            vga_blue  <= '0;
        end else begin
            de_d <= display_enable;
            if (de_d) begin
                vga_red   <= pixel.r;
                vga_green <= pixel.g;
                vga_blue  <= pixel.b;
            end else begin
                vga_red   <= '0;
                vga_green <= '0;
                vga_blue  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_screen_sequencer.sv
// Self-checking bench for screen_sequencer: a frame-level reference model
// checked every cycle, plus literal expectations at scenario milestones.
module tb_screen_sequencer;

    localparam int HEIGHT = 480;
    localparam int START  = 3;
    localparam int DEATH  = 120;
    localparam int OVER   = 300;

    localparam int S_TITLE = 0;
    localparam int S_PLAY  = 1;
    localparam int S_DYING = 2;
    localparam int S_OVER  = 3;
    localparam int S_WIN   = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] row = 32'd0;
    logic [31:0] column = 32'd0;
    logic        display_enable = 1'b0;
    logic        jump_button = 1'b0;
    logic        mario_dead = 1'b0;
    logic        level_done = 1'b0;
    logic [11:0] title_rgb = 12'h000;
    logic [11:0] play_rgb = 12'h000;
    logic [11:0] over_rgb = 12'h000;
    logic [11:0] win_rgb = 12'h000;
    logic [3:0]  vga_red, vga_green, vga_blue;
    logic [2:0]  scene;
    logic [2:0]  lives;
    logic        play_restart;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;
    int restart_seen = 0;
    int tick_seen = 0;

    screen_sequencer #(
        .SCREEN_WIDTH  (640),
        .SCREEN_HEIGHT (HEIGHT),
        .START_LIVES   (START),
        .DEATH_FRAMES  (DEATH),
        .OVER_FRAMES   (OVER)
    ) dut (
        .vga_clock      (clk),
        .reset          (reset),
        .row            (row),
        .column         (column),
        .display_enable (display_enable),
        .jump_button    (jump_button),
        .mario_dead     (mario_dead),
        .level_done     (level_done),
        .title_rgb      (title_rgb),
        .play_rgb       (play_rgb),
        .over_rgb       (over_rgb),
        .win_rgb        (win_rgb),
        .vga_red        (vga_red),
        .vga_green      (vga_green),
        .vga_blue       (vga_blue),
        .scene          (scene),
        .lives          (lives),
        .play_restart   (play_restart),
        .frame_tick     (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model (frame-level rules) ----------------
    int         m_scene;
    int         m_lives;
    int         m_ticks_in_scene;
    bit         m_restart;
    bit         m_tick;
    bit         m_prev_at_pos;
    bit         m_press_hist [4];
    bit         m_press;
    bit         m_pending;
    bit         m_prev_de;
    logic [11:0] m_rgb;

    function automatic logic [11:0] source_for(input int s);
        case (s)
            S_TITLE:        return title_rgb;
            S_PLAY, S_DYING: return play_rgb;
            S_OVER:         return over_rgb;
            default:        return win_rgb;
        endcase
    endfunction

    task automatic model_reset();
        m_scene = S_TITLE;
        m_lives = START;
        m_ticks_in_scene = 0;
        m_restart = 0;
        m_tick = 0;
        m_prev_at_pos = 0;
        for (int i = 0; i < 4; i++) m_press_hist[i] = 0;
        m_press = 0;
        m_pending = 0;
        m_prev_de = 0;
        m_rgb = '0;
    endtask

    task automatic model_step();
        int  next_scene;
        bit  restart;
        bit  at_pos;
        next_scene = m_scene;
        restart = 0;
        // Pixel uses the scene that was current during this cycle.
        m_rgb = m_prev_de ? source_for(m_scene) : 12'h000;
        m_prev_de = display_enable;

        if (m_tick) begin
            case (m_scene)
                S_TITLE: if (m_pending) begin
                    next_scene = S_PLAY; m_lives = START; restart = 1;
                end
                S_PLAY: begin
                    if (mario_dead) next_scene = S_DYING;
                    else if (level_done) next_scene = S_WIN;
                end
                S_DYING: if (m_ticks_in_scene + 1 == DEATH) begin
                    if (m_lives == 1) begin m_lives = 0; next_scene = S_OVER; end
                    else begin m_lives = m_lives - 1; next_scene = S_PLAY; restart = 1; end
                end
                default: if (m_pending && m_ticks_in_scene >= OVER) next_scene = S_TITLE;
            endcase
        end

        // A press is remembered until the next frame tick, never across a scene change.
        if (next_scene != m_scene) m_pending = 0;
        else if (m_tick) m_pending = m_press;
        else if (m_press) m_pending = 1;

        if (next_scene != m_scene) m_ticks_in_scene = 0;
        else if (m_tick) m_ticks_in_scene++;
        m_scene = next_scene;
        m_restart = restart;

        // Button: synchronised and edge-detected three clocks after sampling.
        m_press = m_press_hist[1] && !m_press_hist[2];
        m_press_hist[2] = m_press_hist[1];
        m_press_hist[1] = m_press_hist[0];
        m_press_hist[0] = jump_button;

        at_pos = (row == HEIGHT) && (column == 0);
        m_tick = at_pos && !m_prev_at_pos;
        m_prev_at_pos = at_pos;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (checking) begin
            check("rgb", {20'd0, vga_red, vga_green, vga_blue}, {20'd0, m_rgb});
            check("scene", {29'd0, scene}, m_scene);
            check("lives", {29'd0, lives}, m_lives);
            check("play_restart", {31'd0, play_restart}, {31'd0, m_restart});
            check("frame_tick", {31'd0, frame_tick}, {31'd0, m_tick});
            if (play_restart) restart_seen++;
            if (frame_tick) tick_seen++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_rgb();
        title_rgb = 12'($urandom_range(0, 4095));
        play_rgb  = 12'($urandom_range(0, 4095));
        over_rgb  = 12'($urandom_range(0, 4095));
        win_rgb   = 12'($urandom_range(0, 4095));
    endtask

    // Compact frame: blanking start, one blank line, six visible pixels.
    task automatic run_frame(input bit press);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) begin
                row = 32'(HEIGHT); column = 0; display_enable = 0;
            end else if (i == 1) begin
                row = 32'(HEIGHT + 1); column = 3; display_enable = 0;
            end else begin
                row = 32'd10; column = 32'(i - 2); display_enable = 1;
            end
            jump_button = press && (i == 2 || i == 3);
            drive_rgb();
        end
    endtask

    task automatic run_frames(input int n);
        for (int k = 0; k < n; k++) run_frame(0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 reset = 1;
        #1;
        check("reset_scene", {29'd0, scene}, S_TITLE);
        check("reset_lives", {29'd0, lives}, START);
        check("reset_rgb", {20'd0, vga_red, vga_green, vga_blue}, 32'd0);
        check("reset_restart", {31'd0, play_restart}, 32'd0);
        check("reset_tick", {31'd0, frame_tick}, 32'd0);
        repeat (2) @(negedge clk);
        #2 reset = 0;
    endtask

    initial begin
        int t0;
        repeat (3) @(negedge clk);
        #2 reset = 0;
        checking = 1;
        check("init_scene", {29'd0, scene}, S_TITLE);
        check("init_lives", {29'd0, lives}, 3);
        run_frames(2);

        // Press mid-frame: still TITLE until the following tick.
        run_frame(1);
        check("title_wait", {29'd0, scene}, S_TITLE);
        run_frame(0);
        check("start_scene", {29'd0, scene}, S_PLAY);
        check("start_lives", {29'd0, lives}, 3);
        check("start_restart_cnt", restart_seen, 1);

        // Death has priority over level completion.
        mario_dead = 1; level_done = 1;
        run_frame(0);
        check("dead_priority", {29'd0, scene}, S_DYING);
        mario_dead = 0; level_done = 0;
        run_frames(119);
        check("dying_hold", {29'd0, scene}, S_DYING);
        run_frame(0);
        check("respawn_scene", {29'd0, scene}, S_PLAY);
        check("respawn_lives", {29'd0, lives}, 2);
        check("respawn_restart_cnt", restart_seen, 2);

        // Two more deaths end the game.
        mario_dead = 1;
        run_frames(242);
        mario_dead = 0;
        check("over_scene", {29'd0, scene}, S_OVER);
        check("over_lives", {29'd0, lives}, 0);
        check("over_restart_cnt", restart_seen, 3);

        // Early press discarded, late press accepted.
        run_frames(99);
        run_frame(1);
        run_frames(205);
        check("early_press_ignored", {29'd0, scene}, S_OVER);
        run_frame(1);
        run_frame(0);
        check("late_press_title", {29'd0, scene}, S_TITLE);

        // New game then win.
        run_frame(1);
        run_frame(0);
        check("restart_lives", {29'd0, lives}, 3);
        level_done = 1;
        run_frame(0);
        level_done = 0;
        check("win_scene", {29'd0, scene}, S_WIN);
        run_frames(2);

        // Generator dwelling on the blanking start.
        t0 = tick_seen;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            row = (i < 5) ? 32'(HEIGHT) : 32'(HEIGHT + 1);
            column = 0;
            display_enable = 0;
        end
        check("dwell_single_tick", tick_seen - t0, 1);

        // Reset in the middle of DYING.
        pulse_reset();
        run_frames(1);
        run_frame(1);
        run_frame(0);
        mario_dead = 1;
        run_frame(0);
        mario_dead = 0;
        run_frames(50);
        @(negedge clk);
        row = 32'd10; column = 32'd2; display_enable = 1;
        pulse_reset();
        run_frames(1);
        run_frame(1);
        run_frame(0);
        mario_dead = 1;
        run_frame(0);
        mario_dead = 0;
        run_frames(119);
        check("post_reset_dying", {29'd0, scene}, S_DYING);
        run_frame(0);
        check("post_reset_respawn", {29'd0, scene}, S_PLAY);
        check("post_reset_lives", {29'd0, lives}, 2);
        run_frames(2);

        checking = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/screen_sequencer.md
Name: screen_sequencer

Overview:
- Top-level scene controller for the VGA path.
- Decides which screen drawer (title, gameplay, game-over, win) owns the RGB outputs and tracks lives. Drives per-scene reset/restart pulses.
- Changes scene only at frame boundaries, so no frame ever mixes two scenes.
- Sits between the drawer instances and the VGA pins, sharing the single VGA output between them.

Parameters:
- SCREEN_WIDTH, 640, visible columns
- SCREEN_HEIGHT, 480, visible rows
- START_LIVES, 3, lives loaded on new game (1..7)
- DEATH_FRAMES, 120, frames spent in DYING before respawn or game over
- OVER_FRAMES, 300, minimum frames on GAME_OVER/WIN before a button is accepted

Ports:
- vga_clock  input  1  pixel clock (single clock domain)
- reset  input  1  asynchronous, active-high reset
- row  input  32 (int)  current scan row from timing generator
- column  input  32 (int)  current scan column
- display_enable  input  1  high in visible area
- jump_button  input  1  raw asynchronous button, active-high
- mario_dead  input  1  level-sensitive death flag from gameplay logic
- level_done  input  1  level-sensitive completion flag
- title_rgb, play_rgb, over_rgb, win_rgb  input  12 each  {r,g,b} from each drawer
- vga_red, vga_green, vga_blue  output  4 each  muxed pixel colour
- scene  output  3  current scene encoding (scene_t)
- lives  output  3  remaining lives
- play_restart  output  1  one-cycle pulse that resets the gameplay world
- frame_tick  output  1  one-cycle pulse at the start of vertical blanking

Behaviour:
- Reset values: scene=TITLE, lives=START_LIVES, play_restart=0, frame_tick=0, RGB=0, frame timer=0, button synchroniser=0.
- frame_tick:
  - Registered. Asserted for exactly one cycle on the first vga_clock where row==SCREEN_HEIGHT && column==0, detected by a rising edge of that compare.
  - A frame therefore counts once even if the timing generator holds that position for several cycles.
- Button:
  - 2-flop synchroniser, then rising-edge detect giving btn_pulse (latency 3 cycles).
  - btn_pulse is latched into btn_pending; btn_pending is consumed only at a frame_tick.
  - btn_pending is cleared on every scene change.
- Scene FSM (scene_t): TITLE, PLAYING, DYING, GAME_OVER, WIN. Transitions are evaluated only when frame_tick=1.
  - TITLE: btn_pending → PLAYING; lives=START_LIVES; pulse play_restart.
  - PLAYING: mario_dead → DYING, timer=0. level_done (without mario_dead) → WIN, timer=0. If both flags are high, death has priority.
  - DYING: timer increments per tick. When timer==DEATH_FRAMES-1: if lives==1, lives=0 and go to GAME_OVER, timer=0. Otherwise lives-1, go to PLAYING, pulse play_restart.
  - GAME_OVER / WIN: timer saturates at OVER_FRAMES. btn_pending while timer==OVER_FRAMES → TITLE. Earlier presses are discarded.
- Timer width: clog2(max(DEATH_FRAMES, OVER_FRAMES)+1). Saturating, with no wrap.
- lives never underflows below 0 and never exceeds START_LIVES.
- play_restart is high exactly one cycle: the cycle after the frame_tick that caused the transition.
- RGB mux:
  - Registered, 1-cycle latency from drawer inputs.
  - Output is 0 when display_enable (delayed one cycle to align) is low.
  - Source: TITLE→title_rgb; PLAYING and DYING→play_rgb; GAME_OVER→over_rgb; WIN→win_rgb.
  - The scene used by the mux is the registered scene, which changes only in blanking.
- Reset mid-frame or mid-scene: immediate return to reset values; the first frame_tick after release is handled normally.

Decomposition:
- Package screen_pkg holds:
  - scene_t enum (TITLE=0, PLAYING=1, DYING=2, GAME_OVER=3, WIN=4)
  - rgb12_t packed struct {r,g,b}
  - tile codes BDR/SKY/BLK/GND/TKN as localparams, so drawers and this block share them
- One sub-module: button_edge_sync (2-flop sync plus rising-edge pulse), reusable for left/right switches.

Test Plan:
- Reset with row/column sweeping → scene=TITLE, lives=3, RGB equals title_rgb delayed 1 cycle in visible area, 0 in blanking.
- jump_button pulse mid-frame → scene goes to PLAYING only after the next frame_tick; play_restart is high one cycle; lives=3.
- PLAYING, mario_dead and level_done both high at a frame_tick → DYING (not WIN). After 120 ticks → PLAYING, lives=2, play_restart pulse.
- Three deaths from lives=3 → the third ends in GAME_OVER with lives=0. A button at tick 100 is ignored; a button after tick 300 → TITLE.
- level_done in PLAYING → WIN, mux selects win_rgb. Hold row==480,column==0 for 5 cycles → frame_tick pulses once.
- Assert reset while in DYING with timer=50 → immediately TITLE, lives=3, timer=0, outputs zeroed.
